lu_serial_ctrl: RTL

LU_SERIAL_CTRL -- requirements
Module: lu_serial_ctrl

---
 rtl/lu_serial_ctrl_if.sv | 23 ++
 rtl/lu_serial_ctrl.sv | 97 +++++++++
 2 files changed

// File: rtl/lu_serial_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial logic-unit controller.
interface lu_serial_ctrl_if #(
  parameter int WIDTH = 8
);
  logic                     start;
  logic [1:0]               op;
  logic [WIDTH-1:0]         a;
  logic [WIDTH-1:0]         b;
  logic                     busy;
  logic                     done;
  logic [WIDTH-1:0]         result;
  logic [$clog2(WIDTH)-1:0] bit_idx;

  modport master (
    output start, op, a, b,
    input  busy, done, result, bit_idx
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, bit_idx
  );
endinterface

// File: rtl/lu_serial_ctrl.sv
// Bit-serial bitwise AND/OR/NAND/NOR engine: one 1-bit logic unit, LSB first,
// one bit per clock, with IDLE/RUN/DONE sequencing and back-to-back restart.
module lu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  lu_serial_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_reg, b_reg, sr, res;
  logic [1:0]       op_reg;
  logic [CW-1:0]    cnt;
  logic             lu_bit;
  logic             capture;
  logic             busy, done;
  logic [WIDTH-1:0] sr_nx;

  // op[1] inverts the output, op[0] picks OR over AND
  function automatic logic lu(input logic x, input logic y, input logic [1:0] op);
    logic r;
    r = op[0] ? (x | y) : (x & y);
    return op[1] ? ~r : r;
  endfunction

  assign lu_bit = lu(a_reg[cnt], b_reg[cnt], op_reg);
  assign sr_nx  = {lu_bit, sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = RUN;
          capture  = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (bus.start) begin
          state_nx = RUN;
          capture  = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operands are captured once so mid-run input changes cannot leak in;
  // the counter parks on the last bit instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= '0;
      cnt    <= '0;
      sr     <= '0;
      res    <= '0;
    end else if (capture) begin
      a_reg  <= bus.a;
      b_reg  <= bus.b;
      op_reg <= bus.op;
      cnt    <= '0;
      sr     <= '0;
    end else if (state == RUN) begin
      sr <= sr_nx;
      if (cnt == LAST) res <= sr_nx;
      else             cnt <= cnt + CW'(1);
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.result  = res;
  assign bus.bit_idx = (state == RUN) ? cnt : '0;

endmodule
